a2d_intf: RTL and testbench

Conversion responder for the motion controller's A2D request port. It takes `strt_cnv`/`chnnl` from the controller and runs two back-to-back 16-bit SPI mode-3 transactions to the external 8-channel ADC. The first transaction sends the channel command. The second retrieves the 12-bit result, which is returned on `res` with a sticky `cnv_cmplt`. It sits between `motion_cntrl` and the IR sensor ADC pins.

---
 rtl/a2d_intf.sv | 150 +++++++++++++++
 tb/tb_a2d_intf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// a2d_intf: SPI mode-3 master that sends a channel command frame, waits GAP_CLKS, then reads a 12-bit result frame (A2D_RES_INV_EN inverts res).
// Latency: accept to cnv_cmplt = 1 + 521 + GAP_CLKS + 521 + 1 clk; strt_cnv is dropped while a conversion is in flight (no backpressure).
module a2d_intf #(
    parameter int GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    localparam int              GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [4:0]      DIV_LOAD = 5'b10111;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {IDLE, XFER1, GAP, XFER2, PORCH} state_t;

    state_t         state_q, state_d;
    logic           pend_q, pend_d;
    logic [2:0]     chnnl_q, chnnl_d;
    logic [15:0]    shft_q, shft_d;
    logic [4:0]     sclk_div_q, sclk_div_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic           miso_smpl_q, miso_smpl_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           ss_n_q, ss_n_d;
    logic           cmplt_q, cmplt_d;
    logic [11:0]    res_q, res_d;
    logic           in_xfer, xfer_end;

    assign in_xfer  = (state_q == XFER1) || (state_q == XFER2);
    assign xfer_end = in_xfer && (sclk_div_q == 5'b11111) && (bit_cnt_q == 5'd16);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        chnnl_d     = chnnl_q;
        shft_d      = shft_q;
        sclk_div_d  = sclk_div_q;
        bit_cnt_d   = bit_cnt_q;
        miso_smpl_d = miso_smpl_q;
        gap_cnt_d   = gap_cnt_q;
        cmplt_d     = cmplt_q;
        res_d       = res_q;

        // Shared shift engine; SCLK is sclk_div[4], so a reload to DIV_LOAD parks it high.
        if (in_xfer) begin
            sclk_div_d = sclk_div_q + 5'd1;
            if (sclk_div_q == 5'b01111) begin
                miso_smpl_d = MISO;
                bit_cnt_d   = bit_cnt_q + 5'd1;
            end
            if ((sclk_div_q == 5'b11111) && (bit_cnt_q != 5'd0)) begin
                shft_d = {shft_q[14:0], miso_smpl_q};
            end
        end else begin
            sclk_div_d = DIV_LOAD;
            bit_cnt_d  = 5'd0;
        end

        case (state_q)
            IDLE: begin
                // One setup clock after accept before SS_n drops.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = XFER1;
                end else if (strt_cnv) begin
                    pend_d  = 1'b1;
                    chnnl_d = chnnl;
                    shft_d  = {2'b00, chnnl, 11'h000};
                    cmplt_d = 1'b0;
                end
            end
            XFER1: begin
                if (xfer_end) begin
                    state_d    = GAP;
                    gap_cnt_d  = '0;
                    shft_d     = {2'b00, chnnl_q, 11'h000};
                    sclk_div_d = DIV_LOAD;
                    bit_cnt_d  = 5'd0;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = XFER2;
                end
            end
            XFER2: begin
                if (xfer_end) begin
                    state_d    = PORCH;
                    sclk_div_d = DIV_LOAD;
                    bit_cnt_d  = 5'd0;
                end
            end
            PORCH: begin
`ifdef A2D_RES_INV_EN
                res_d   = ~shft_q[11:0];
`else
                res_d   = shft_q[11:0];
`endif
                cmplt_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ss_n_d = !((state_d == XFER1) || (state_d == XFER2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            chnnl_q     <= 3'd0;
            shft_q      <= 16'h0000;
            sclk_div_q  <= DIV_LOAD;
            bit_cnt_q   <= 5'd0;
            miso_smpl_q <= 1'b0;
            gap_cnt_q   <= '0;
            ss_n_q      <= 1'b1;
            cmplt_q     <= 1'b0;
            res_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            chnnl_q     <= chnnl_d;
            shft_q      <= shft_d;
            sclk_div_q  <= sclk_div_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_smpl_q <= miso_smpl_d;
            gap_cnt_q   <= gap_cnt_d;
            ss_n_q      <= ss_n_d;
            cmplt_q     <= cmplt_d;
            res_q       <= res_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_div_q[4];
    assign MOSI      = shft_q[15];
    assign cnv_cmplt = cmplt_q;
    assign res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural ADC (mode-3 slave returning the channel addressed in the previous frame) plus pin-level frame monitor.
`timescale 1ns/1ps
module tb_a2d_intf;
    logic        clk = 1'b0;
    logic        rst_n, strt_cnv, MISO;
    logic [2:0]  chnnl;
    logic        cnv_cmplt, SS_n, SCLK, MOSI;
    logic [11:0] res;

    always #5 clk = ~clk;

    a2d_intf #(.GAP_CLKS(32)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .SS_n(SS_n), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO)
    );

    int n_vec = 0;
    int n_fail = 0;
    logic [11:0] adc_mem [8];

    // Frame records, one entry per SS_n low window.
    int          win_len_q[$];
    int          win_rise_q[$];
    int          gap_q[$];
    logic [15:0] win_cmd_q[$];
    int          stray_edges = 0;

    logic        prev_ss = 1'b1, prev_sclk = 1'b1, seen_end = 1'b0;
    int          cur_len = 0, cur_rise = 0, cur_fall = 0, cur_gap = 0;
    logic [15:0] cur_cmd = 16'h0, tx = 16'h0;
    logic [2:0]  last_ch = 3'd0;

    always @(negedge clk) begin
        if (!rst_n) MISO = 1'b0;
        if (prev_ss && !SS_n) begin
            gap_q.push_back(seen_end ? cur_gap : 0);
            cur_len = 0; cur_rise = 0; cur_fall = 0; cur_cmd = 16'h0;
            tx = {4'h0, adc_mem[last_ch]};
        end
        if (!SS_n) begin
            cur_len++;
            if (prev_sclk && !SCLK && cur_fall < 16) begin
                MISO = tx[15 - cur_fall];
                cur_fall++;
            end
            if (!prev_sclk && SCLK) begin
                cur_cmd = {cur_cmd[14:0], MOSI};
                cur_rise++;
            end
        end else begin
            if (prev_sclk != SCLK) stray_edges++;
            if (!prev_ss) begin
                win_len_q.push_back(cur_len);
                win_rise_q.push_back(cur_rise);
                win_cmd_q.push_back(cur_cmd);
                if (cur_rise == 16) last_ch = cur_cmd[13:11];
                seen_end = 1'b1;
                cur_gap = 0;
            end
            cur_gap++;
        end
        prev_ss = SS_n;
        prev_sclk = SCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_res(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Called #1 after a rising edge; returns #1 after the completion edge (or timeout).
    task automatic convert(input logic [2:0] ch, input int inj_at, input int post);
        int w0, s0, n;
        logic [11:0] old_res;
        logic res_moved;
        logic [15:0] cmd_exp;
        w0 = win_len_q.size();
        s0 = stray_edges;
        old_res = res;
        cmd_exp = {2'b00, ch, 11'h000};
        strt_cnv = 1'b1;
        chnnl = ch;
        @(posedge clk); #1;
        strt_cnv = 1'b0;
        chnnl = 3'($urandom_range(0, 7));
        chk("cmplt_clear", 32'(cnv_cmplt), 32'd0);
        n = 0;
        res_moved = 1'b0;
        while (n < 1200) begin
            if (n == inj_at) begin strt_cnv = 1'b1; chnnl = 3'd3; end
            else strt_cnv = 1'b0;
            @(posedge clk); #1;
            n++;
            if (cnv_cmplt) break;
            if (res !== old_res) res_moved = 1'b1;
        end
        strt_cnv = 1'b0;
        chk("latency", n, 1076);
        chk("res_held", 32'(res_moved), 32'd0);
        chk("res", 32'(res), 32'(exp_res(adc_mem[ch])));
        chk("windows", win_len_q.size() - w0, 2);
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = w0 + k;
            chk("win_len", (idx < win_len_q.size()) ? win_len_q[idx] : -1, 521);
            chk("win_rises", (idx < win_rise_q.size()) ? win_rise_q[idx] : -1, 16);
            chk("win_cmd", (idx < win_cmd_q.size()) ? 32'(win_cmd_q[idx]) : 32'hFFFF_FFFF, 32'(cmd_exp));
        end
        chk("gap_len", (w0 + 1 < gap_q.size()) ? gap_q[w0 + 1] : -1, 32);
        chk("stray_sclk", stray_edges - s0, 0);
        if (post > 0) begin
            repeat (post) @(posedge clk);
            #1;
            chk("no_extra_window", win_len_q.size() - w0, 2);
            chk("post_ss_n", 32'(SS_n), 32'd1);
        end
    endtask

    initial begin
        logic [2:0] rch;
        rst_n = 1'b1;
        strt_cnv = 1'b0;
        chnnl = 3'd0;
        for (int i = 0; i < 8; i++) adc_mem[i] = 12'(12'h100 * i + 12'h0F1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_ss_n", 32'(SS_n), 32'd1);
        chk("idle_sclk", 32'(SCLK), 32'd1);
        chk("idle_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("idle_res", 32'(res), 32'd0);
        chk("idle_toggles", stray_edges, 0);
        chk("idle_windows", win_len_q.size(), 0);

        adc_mem[5] = 12'hA5C;
        convert(3'd5, -1, 0);
        chk("ch5_cmd0", (win_cmd_q.size() > 1) ? 32'(win_cmd_q[0]) : 32'hFFFF_FFFF, 32'h2800);
        chk("ch5_cmd1", (win_cmd_q.size() > 1) ? 32'(win_cmd_q[1]) : 32'hFFFF_FFFF, 32'h2800);

        // Back-to-back sweep over every channel.
        adc_mem[5] = 12'h5F1;
        for (int c = 0; c < 8; c++) convert(3'(c), -1, 0);

        // A request landing mid-XFER2 must be dropped.
        convert(3'd1, 800, 40);

        // Reset 300 clk into XFER1 aborts the frame with no result.
        rch = 3'($urandom_range(0, 7));
        strt_cnv = 1'b1;
        chnnl = rch;
        @(posedge clk); #1;
        strt_cnv = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        chk("busy_before_rst", 32'(SS_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", 32'(SS_n), 32'd1);
        chk("abort_sclk", 32'(SCLK), 32'd1);
        chk("abort_mosi", 32'(MOSI), 32'd0);
        chk("abort_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("abort_res", 32'(res), 32'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("after_rst_ss_n", 32'(SS_n), 32'd1);
        chk("after_rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("after_rst_res", 32'(res), 32'd0);
        convert(3'd2, -1, 0);

        adc_mem[6] = 12'h3C0;
        convert(3'd6, -1, 0);

        repeat (5) begin
            int idle;
            rch = 3'($urandom_range(0, 7));
            adc_mem[rch] = 12'($urandom);
            idle = $urandom_range(0, 20);
            repeat (idle) @(posedge clk);
            if (idle > 0) #1;
            convert(rch, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
